tour_cmd_sequencer: RTL and testbench

- Synthesizable scripted command driver for the Knight's Tour system: holds a programmable queue of 16-bit commands, issues them one at a time to the `RemoteComm` command port, waits for each acknowledge, and reports pass/fail.
- Sits between a host/bench source and `RemoteComm`, which then talks over UART to `KnightsTour`.
- Generalises the single-command send / wait-ack sequence into a parametrised multi-command run with per-command timeouts, NAK detection and error reporting.

---
 rtl/tour_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tour_cmd_sequencer
//
// Scripted command driver for the Knight's Tour system. A host loads a FIFO
// of 16-bit commands. On `start` the commands are issued one at a time to
// RemoteComm. After each command the block waits for the transmit-complete
// strobe and then for a response byte. The run ends with pass when every
// command has been acknowledged, or with fail plus a cause code and the
// index of the failing command.
//
// Build option:
//   SEQ_RETRY_EN - when defined, a NAK or a timeout re-sends the same command
//                  once before the run is failed. An abort never retries.
//
// Parameters:
//   DEPTH    queue entries (power of two, >= 2)
//   TIMEOUT  cycles allowed in each wait phase (>= 2)
//   ACK      positive acknowledge byte
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_cmd     enqueue a command (accepted only when idle/done and not full)
//   start, abort      begin a run / terminate a run in progress
//   cmd, snd_cmd      command word and one-cycle send strobe to RemoteComm
//   cmd_snt           RemoteComm finished transmitting
//   resp_rdy, resp    response byte strobe and value
//   busy              run in progress (SEND / WAIT_SNT / WAIT_RESP)
//   done, pass, fail  sticky run status, cleared by the next start
//   err_code          00 NAK, 01 cmd_snt timeout, 10 response timeout, 11 abort
//   err_idx           index of the failing command, counted from run start
//   count, full       queue occupancy and full flag
// -----------------------------------------------------------------------------
module tour_cmd_sequencer #(
  parameter int         DEPTH   = 8,
  parameter int         TIMEOUT = 1000000,
  parameter logic [7:0] ACK     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [15:0]              wr_cmd,
  input  logic                     start,
  input  logic                     abort,
  output logic [15:0]              cmd,
  output logic                     snd_cmd,
  input  logic                     cmd_snt,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMR_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NAK   = 2'b00;
  localparam logic [1:0] ERR_SNT   = 2'b01;
  localparam logic [1:0] ERR_RESP  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

`ifdef SEQ_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SNT  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          retry_q, retry_d;
  logic          snd_cmd_q, snd_cmd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic          full_q, full_d;

  logic          wr_accept;
  logic          fail_req;
  logic [1:0]    fail_code;
  logic          retry_take;
  logic [AW-1:0] nxt_ptr;

  // Next-state, queue bookkeeping and registered-output computation.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cmd_d      = cmd_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    wr_accept  = 1'b0;
    fail_req   = 1'b0;
    fail_code  = ERR_NAK;
    nxt_ptr    = rd_ptr_q + PTR_ONE;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_en && (count_q != CNT_FULL)) begin
          wr_accept = 1'b1;
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          count_d   = count_q + CNT_ONE;
        end else begin
          wr_accept = 1'b0;
        end
        if (start) begin
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          err_code_d = ERR_NAK;
          err_idx_d  = PTR_ZERO;
          idx_d      = PTR_ZERO;
          retry_d    = 1'b0;
          if (count_q == CNT_ZERO) begin
            // Nothing to send: an empty run is trivially successful.
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            cmd_d   = mem_q[rd_ptr_q];
            state_d = ST_SEND;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_SEND: begin
        if (abort) begin
          fail_req  = 1'b1;
          fail_code = ERR_ABORT;
        end else begin
          state_d = ST_WAIT_SNT;
          tmr_d   = TMR_ZERO;
        end
      end

      ST_WAIT_SNT, ST_WAIT_RESP: begin
        // Priority: abort, then a response (even one that arrives before
        // cmd_snt), then cmd_snt, then the timeout.
        if (abort) begin
          fail_req  = 1'b1;
          fail_code = ERR_ABORT;
        end else if (resp_rdy && (resp == ACK)) begin
          rd_ptr_d = nxt_ptr;
          count_d  = count_q - CNT_ONE;
          idx_d    = idx_q + PTR_ONE;
          retry_d  = 1'b0;
          if (count_q == CNT_ONE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            cmd_d   = mem_q[nxt_ptr];
            state_d = ST_SEND;
          end
        end else if (resp_rdy) begin
          fail_req  = 1'b1;
          fail_code = ERR_NAK;
        end else if (cmd_snt && (state_q == ST_WAIT_SNT)) begin
          state_d = ST_WAIT_RESP;
          tmr_d   = TMR_ZERO;
        end else if (tmr_q == TMR_LAST) begin
          fail_req  = 1'b1;
          fail_code = (state_q == ST_WAIT_SNT) ? ERR_SNT : ERR_RESP;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // One re-send per command is allowed for NAK/timeout in the retry build.
    retry_take = fail_req && RETRY_EN && (fail_code != ERR_ABORT) && !retry_q;

    if (retry_take) begin
      retry_d = 1'b1;
      state_d = ST_SEND;
    end else if (fail_req) begin
      // Failure flushes the queue so the next load starts from a clean FIFO.
      state_d    = ST_DONE;
      done_d     = 1'b1;
      pass_d     = 1'b0;
      fail_d     = 1'b1;
      err_code_d = fail_code;
      err_idx_d  = idx_q;
      count_d    = CNT_ZERO;
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
    end else begin
      retry_d = retry_d;
    end

    snd_cmd_d = (state_d == ST_SEND);
    busy_d    = (state_d == ST_SEND) || (state_d == ST_WAIT_SNT) ||
                (state_d == ST_WAIT_RESP);
    full_d    = (count_d == CNT_FULL);
  end

  // Command storage; not reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_cmd;
    end
  end

  // State, pointer, timer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      cmd_q      <= 16'h0000;
      tmr_q      <= TMR_ZERO;
      idx_q      <= PTR_ZERO;
      retry_q    <= 1'b0;
      snd_cmd_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_code_q <= 2'b00;
      err_idx_q  <= PTR_ZERO;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_q      <= cmd_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      snd_cmd_q  <= snd_cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      full_q     <= full_d;
    end
  end

  assign cmd      = cmd_q;
  assign snd_cmd  = snd_cmd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;
  assign count    = count_q;
  assign full     = full_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tour_cmd_sequencer
//
// Randomized bench for tour_cmd_sequencer. Each run loads a queue, starts
// it, and answers every send with an action (ACK, NAK, timeout, abort). The
// expected outcome of every action, the queue contents and the error index
// come from a queue-level reference model kept here.
// -----------------------------------------------------------------------------
module tb_tour_cmd_sequencer;

  localparam int         DEPTH   = 8;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] ACK     = 8'hA5;
  localparam int         AW      = 3;

`ifdef SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef enum int {
    A_ACK, A_EARLY_ACK, A_NAK, A_EARLY_NAK, A_TO_SNT, A_TO_RESP,
    A_AB_SEND, A_AB_SNT, A_AB_RESP
  } act_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [15:0]   wr_cmd;
  logic          start;
  logic          abort;
  logic [15:0]   cmd;
  logic          snd_cmd;
  logic          cmd_snt;
  logic          resp_rdy;
  logic [7:0]    resp;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic [1:0]    err_code;
  logic [AW-1:0] err_idx;
  logic [AW:0]   count;
  logic          full;

  int total = 0;
  int bad   = 0;

  act_t        plan[$];
  logic [15:0] dir_cmds[$];

  always #5 clk = ~clk;

  tour_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .ACK     (ACK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_cmd   (wr_cmd),
    .start    (start),
    .abort    (abort),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .err_code (err_code),
    .err_idx  (err_idx),
    .count    (count),
    .full     (full)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_en    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
  endtask

  // Reference outcome of one attempt: -1 = accepted, else the failure cause.
  function automatic int expect_of(input act_t a);
    case (a)
      A_ACK, A_EARLY_ACK: return -1;
      A_NAK, A_EARLY_NAK: return 0;
      A_TO_SNT:           return 1;
      A_TO_RESP:          return 2;
      default:            return 3;
    endcase
  endfunction

  function automatic act_t pick_action();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45)      return A_ACK;
    else if (r < 60) return A_EARLY_ACK;
    else if (r < 70) return A_NAK;
    else if (r < 75) return A_EARLY_NAK;
    else if (r < 79) return A_TO_SNT;
    else if (r < 83) return A_TO_RESP;
    else if (r < 88) return A_AB_SEND;
    else if (r < 94) return A_AB_SNT;
    else             return A_AB_RESP;
  endfunction

  function automatic logic [7:0] nak_byte();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == ACK) v = 8'h5A;
    return v;
  endfunction

  // Plays the RemoteComm side for one attempt, starting in the SEND cycle.
  task automatic drive(input act_t a);
    logic [7:0] rb;
    int d;
    rb = ((a == A_ACK) || (a == A_EARLY_ACK)) ? ACK : nak_byte();
    if (a == A_AB_SEND) begin
      abort = 1'b1;
      step(); clear_inputs();
      return;
    end
    // A response during SEND must be ignored.
    resp_rdy = 1'($urandom_range(0, 1));
    resp     = ACK;
    step(); clear_inputs();
    check_eq("snd_pulse", 32'(snd_cmd), 32'(0));
    if (a == A_TO_SNT) begin
      repeat (TIMEOUT - 1) step();
      check_eq("to_snt_early", 32'({fail, snd_cmd}), 32'(0));
      step();
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) begin
      wr_en  = 1'b1;
      wr_cmd = 16'($urandom);
      start  = 1'($urandom_range(0, 1));
      step(); clear_inputs();
    end
    if (a == A_AB_SNT) begin
      abort    = 1'b1;
      cmd_snt  = 1'($urandom_range(0, 1));
      resp_rdy = 1'($urandom_range(0, 1));
      resp     = ACK;
      step(); clear_inputs();
      return;
    end
    if ((a == A_EARLY_ACK) || (a == A_EARLY_NAK)) begin
      resp_rdy = 1'b1;
      resp     = rb;
      cmd_snt  = 1'($urandom_range(0, 1));
      step(); clear_inputs();
      return;
    end
    cmd_snt = 1'b1;
    step(); clear_inputs();
    if (a == A_TO_RESP) begin
      repeat (TIMEOUT - 1) begin
        cmd_snt = 1'($urandom_range(0, 1));
        step();
      end
      clear_inputs();
      check_eq("to_resp_early", 32'({fail, snd_cmd}), 32'(0));
      step();
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) begin
      cmd_snt = 1'($urandom_range(0, 1));
      step(); clear_inputs();
    end
    if (a == A_AB_RESP) begin
      abort    = 1'b1;
      resp_rdy = 1'b1;
      resp     = ACK;
      step(); clear_inputs();
      return;
    end
    resp_rdy = 1'b1;
    resp     = rb;
    step(); clear_inputs();
  endtask

  // Loads n_push commands, runs them and checks against the queue model.
  task automatic run_seq(input int n_push);
    logic [15:0] q[$];
    logic [15:0] c;
    act_t        a;
    int          res;
    int          idx;
    bit          used;
    for (int i = 0; i < n_push; i++) begin
      if (dir_cmds.size() > 0) c = dir_cmds.pop_front();
      else c = 16'($urandom);
      wr_en  = 1'b1;
      wr_cmd = c;
      abort  = 1'($urandom_range(0, 1));
      step(); clear_inputs();
      if (q.size() < DEPTH) q.push_back(c);
    end
    check_eq("count_load", 32'(count), 32'(q.size()));
    check_eq("full_load", 32'(full), 32'(q.size() == DEPTH));
    start = 1'b1;
    step(); clear_inputs();
    check_eq("start_clr_fail", 32'(fail), 32'(0));
    if (q.size() == 0) begin
      check_eq("empty_done", 32'({done, pass}), 32'(3));
      check_eq("empty_snd", 32'({snd_cmd, busy}), 32'(0));
    end
    idx  = 0;
    used = 1'b0;
    while (q.size() > 0) begin
      check_eq("snd_cmd", 32'(snd_cmd), 32'(1));
      check_eq("cmd", 32'(cmd), 32'(q[0]));
      check_eq("busy", 32'(busy), 32'(1));
      check_eq("count_run", 32'(count), 32'(q.size()));
      if (plan.size() > 0) a = plan.pop_front();
      else a = pick_action();
      drive(a);
      res = expect_of(a);
      if (res < 0) begin
        void'(q.pop_front());
        idx++;
        used = 1'b0;
        if (q.size() == 0) begin
          check_eq("pass_flags", 32'({done, pass, fail}), 32'(6));
          check_eq("pass_count", 32'(count), 32'(0));
          check_eq("pass_idle", 32'({busy, snd_cmd}), 32'(0));
        end
      end else if (RETRY && (res != 3) && !used) begin
        used = 1'b1;
      end else begin
        check_eq("fail_flags", 32'({done, pass, fail}), 32'(5));
        check_eq("err_code", 32'(err_code), 32'(res));
        check_eq("err_idx", 32'(err_idx), 32'(idx));
        check_eq("fail_count", 32'(count), 32'(0));
        check_eq("fail_busy", 32'(busy), 32'(0));
        q.delete();
        repeat (3) begin
          step();
          check_eq("no_snd_after_fail", 32'(snd_cmd), 32'(0));
        end
        check_eq("fail_sticky", 32'(fail), 32'(1));
      end
    end
    plan.delete();
    dir_cmds.delete();
    step();
    check_eq("done_sticky", 32'(done), 32'(1));
  endtask

  initial begin
    rst_n  = 1'b0;
    wr_cmd = 16'h0000;
    resp   = 8'h00;
    clear_inputs();
    repeat (3) step();
    check_eq("rst_cmd", 32'(cmd), 32'(0));
    check_eq("rst_flags", 32'({snd_cmd, busy, done, pass, fail, full}), 32'(0));
    check_eq("rst_err", 32'({err_code, err_idx}), 32'(0));
    check_eq("rst_count", 32'(count), 32'(0));
    rst_n = 1'b1;
    step();

    // Three acknowledged commands.
    dir_cmds = '{16'h2000, 16'h43F3, 16'h5BF2};
    plan     = '{A_ACK, A_ACK, A_ACK};
    run_seq(3);

    // Empty queue.
    run_seq(0);

    // NAK on the second command.
    dir_cmds = '{16'h2000, 16'h43F3, 16'h5BF2};
    plan     = '{A_ACK, A_NAK, A_ACK, A_ACK};
    run_seq(3);

    // Timeouts in each wait phase.
    plan = '{A_TO_SNT, A_TO_SNT};
    run_seq(1);
    plan = '{A_TO_RESP, A_TO_RESP};
    run_seq(2);

    // Overfill: ninth write dropped.
    plan = '{A_ACK, A_ACK, A_ACK, A_ACK, A_ACK, A_ACK, A_ACK, A_ACK};
    run_seq(9);

    // Abort colliding with an ACK in WAIT_RESP.
    plan = '{A_AB_RESP};
    run_seq(3);

    // Random runs.
    repeat (30) run_seq($urandom_range(0, 9));

    // Reset in the middle of a run.
    for (int i = 0; i < 3; i++) begin
      wr_en  = 1'b1;
      wr_cmd = 16'($urandom);
      step(); clear_inputs();
    end
    start = 1'b1;
    step(); clear_inputs();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_cmd", 32'(cmd), 32'(0));
    check_eq("async_rst_flags", 32'({snd_cmd, busy, done, pass, fail, full}), 32'(0));
    check_eq("async_rst_rest", 32'({err_code, err_idx, count}), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_idle", 32'({busy, done, count}), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
